// File: rtl/prog_sequencer_if.sv
// Handshake bundle between the test harness/core and the run sequencer.
// The harness side drives Req/Halt; the sequencer side drives the rest.
interface prog_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);

  logic             Req;
  logic             Halt;
  logic             CoreStart;
  logic [PC_W-1:0]  StartAddr;
  logic [1:0]       ProgIdx;
  logic             Busy;
  logic             Ack;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    output Req,
    output Halt,
    input  CoreStart,
    input  StartAddr,
    input  ProgIdx,
    input  Busy,
    input  Ack,
    input  Timeout,
    input  CycleCount
  );

  modport slave (
    input  Req,
    input  Halt,
    output CoreStart,
    output StartAddr,
    output ProgIdx,
    output Busy,
    output Ack,
    output Timeout,
    output CycleCount
  );

endinterface

// File: rtl/prog_sequencer.sv
// Run controller: turns harness Req edges into fetch-unit load pulses, times
// each program run against a watchdog and reports completion via Ack.
module prog_sequencer #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned NUM_PROGS = 3,
  parameter int unsigned START0    = 0,
  parameter int unsigned START1    = 0,
  parameter int unsigned START2    = 0,
  parameter int unsigned START3    = 0,
  parameter int unsigned TIMEOUT   = 32'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] TimeoutLimit = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LastCount    = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LastProg     = 2'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    FAULT
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             reqD;
  logic             reqEdge;
  logic [1:0]       progIdx;
  logic [1:0]       progIdxNext;
  logic [CNT_W-1:0] cycleCount;
  logic [CNT_W-1:0] cycleCountNext;
  logic             timeoutFlag;
  logic             timeoutNext;
  logic             coreStart;
  logic             busy;
  logic             ack;
  logic [PC_W-1:0]  startAddr;

  assign reqEdge = bus.Req & ~reqD;

  // Start-address decode; unpopulated program slots fall back to program 0.
  always_comb begin
    startAddr = PC_W'(START0);
    if (32'(progIdx) < NUM_PROGS) begin
      case (progIdx)
        2'd1:    startAddr = PC_W'(START1);
        2'd2:    startAddr = PC_W'(START2);
        2'd3:    startAddr = PC_W'(START3);
        default: startAddr = PC_W'(START0);
      endcase
    end
  end

  // Next-state, counter and watchdog decisions.
  always_comb begin
    stateNext      = state;
    progIdxNext    = progIdx;
    cycleCountNext = cycleCount;
    timeoutNext    = timeoutFlag;

    case (state)
      IDLE, DONE, FAULT: begin
        if (reqEdge) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        stateNext      = RUN;
        cycleCountNext = '0;
        timeoutNext    = 1'b0;
      end
      RUN: begin
        // Halt has priority so a program ending on the last allowed cycle is not a fault.
        if (bus.Halt) begin
          stateNext = DONE;
        end else if (cycleCount == LastCount) begin
          stateNext      = FAULT;
          cycleCountNext = TimeoutLimit;
          timeoutNext    = 1'b1;
        end else begin
          cycleCountNext = cycleCount + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (state == RUN && stateNext != RUN) begin
      progIdxNext = (progIdx == LastProg) ? 2'd0 : progIdx + 2'd1;
    end
  end

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      reqD        <= 1'b0;
      progIdx     <= 2'd0;
      cycleCount  <= '0;
      timeoutFlag <= 1'b0;
      coreStart   <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
    end else begin
      state       <= stateNext;
      reqD        <= bus.Req;
      progIdx     <= progIdxNext;
      cycleCount  <= cycleCountNext;
      timeoutFlag <= timeoutNext;
      coreStart   <= (stateNext == LOAD);
      busy        <= (stateNext == LOAD) || (stateNext == RUN);
      ack         <= (stateNext == DONE) || (stateNext == FAULT);
    end
  end

  assign bus.CoreStart  = coreStart;
  assign bus.StartAddr  = startAddr;
  assign bus.ProgIdx    = progIdx;
  assign bus.Busy       = busy;
  assign bus.Ack        = ack;
  assign bus.Timeout    = timeoutFlag;
  assign bus.CycleCount = cycleCount;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Run controller that sits between the top-level req/ack handshake and the instruction-fetch/PC block. It selects the start address for the next program, pulses the fetch unit to load it, and watches the core's halt decode. It counts execution cycles, enforces a watchdog timeout, and drives ack back to the test harness. It replaces ad-hoc wiring of req/ack and the free-running cycle counter in the top level.

Parameters:
PC_W, 10, width of program counter / start address
CNT_W, 16, width of cycle counter
NUM_PROGS, 3, number of programs in instruction ROM (1..4)
START0, 0, PC start address of program 0
START1, 0, PC start address of program 1
START2, 0, PC start address of program 2
START3, 0, PC start address of program 3
TIMEOUT, 16'hFFFF, watchdog limit in RUN cycles (>=2)

Ports:
Clk  in  1  clock, posedge
Reset  in  1  synchronous, active-high reset
Req  in  1  start-next-program request from harness (level; rising edge acts)
Halt  in  1  core halt decode (instruction == 0), valid every cycle
CoreStart  out  1  one-cycle pulse to fetch unit: load StartAddr into PC
StartAddr  out  PC_W  PC target for current program
ProgIdx  out  2  index of current/next program
Busy  out  1  high in LOAD or RUN
Ack  out  1  program finished (normal or timeout)
Timeout  out  1  watchdog expired on last run
CycleCount  out  CNT_W  RUN cycles of current/last program

Behaviour:
- Clock Clk, reset Reset: one clock; reset is synchronous and active-high.
- Req edge detect: register Req_d; ReqEdge = Req & ~Req_d. Req_d resets to 0. A Req held high through reset produces an edge on the first post-reset cycle.
- Reset, checked every edge, from any state including mid-RUN:
  - state=IDLE; ProgIdx=0; CycleCount=0.
  - CoreStart=0, Ack=0, Timeout=0, Busy=0.
- StartAddr is combinational: START[ProgIdx]. Any ProgIdx >= NUM_PROGS decodes START0.
- IDLE: Ack=0. ReqEdge -> LOAD. Halt is ignored.
- LOAD, exactly one cycle:
  - CoreStart=1, Busy=1.
  - Clears CycleCount=0 and Timeout=0 at the closing edge.
  - Next state RUN unconditionally.
- RUN: Busy=1. Per edge, in priority order:
  - Halt=1 -> DONE; CycleCount not incremented. Halt wins over timeout when both occur on the same edge.
  - Else CycleCount==TIMEOUT-1 -> FAULT; CycleCount becomes TIMEOUT; Timeout<=1.
  - Else CycleCount+1.
  - Req edges during LOAD/RUN are ignored (not queued).
- On transition into DONE or FAULT: ProgIdx <= (ProgIdx==NUM_PROGS-1) ? 0 : ProgIdx+1.
- DONE: Ack=1, Busy=0. CycleCount and Timeout are held. ReqEdge -> LOAD, and Ack drops in that LOAD cycle.
- FAULT: Ack=1, Timeout=1. Otherwise identical to DONE.
- Latency:
  - ReqEdge sampled at edge N gives CoreStart high in cycle N+1 and RUN from edge N+2.
  - Halt sampled at edge M gives Ack high in cycle M+1.
- Program whose first instruction is halt: CycleCount=0 and Ack one cycle after entering RUN.
- CycleCount never wraps; maximum value is TIMEOUT.

Test Plan:
- Reset, then Req rise; Halt after 5 RUN cycles -> CoreStart pulse 1 cycle, StartAddr=START0; Ack=1, CycleCount=5, Timeout=0, ProgIdx=1.
- Three back-to-back runs with NUM_PROGS=3 and START0/1/2=0/40/120 -> StartAddr 0, 40, 120 at the three CoreStart pulses; ProgIdx wraps to 0 after the third Ack.
- TIMEOUT=8, Halt never asserted -> FAULT after 8 RUN cycles; Ack=1, Timeout=1, CycleCount=8; the next Req clears Timeout in LOAD.
- Halt and CycleCount==TIMEOUT-1 on the same edge -> DONE, Timeout=0, CycleCount=TIMEOUT-1.
- Req toggled during RUN -> no extra CoreStart; Reset asserted mid-RUN -> next cycle IDLE, ProgIdx=0, CycleCount=0, Ack=0.
- Req held high across Ack and not released -> no new run until Req falls and rises again.
